// File: rtl/inst_fetch_resp.sv
// Instruction-memory responder: accepts fetch requests, returns words after WAIT_CYC wait states.
// Optional response/error counters are built when INST_FETCH_RESP_STATS_EN is defined.
module inst_fetch_resp #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                DEPTH_LOG2 = 10,
   parameter int                WAIT_CYC   = 1,
   parameter logic [DATA_W-1:0] NOP_WORD   = 'h00000013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_W-1:0]     req_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_data,
   output logic                  rsp_err,
   input  logic                  ld_we,
   input  logic [DEPTH_LOG2-1:0] ld_addr,
   input  logic [DATA_W-1:0]     ld_wdata,
   output logic [31:0]           fetch_cnt,
   output logic [15:0]           err_cnt
);

   localparam int         DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t              state_q;
   logic [3:0]          cnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic                rsp_err_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                accept;
   logic                enter_resp;
   logic                cap_err;
   logic [ADDR_W-1:0]   cap_addr;
   logic [DEPTH_LOG2-1:0] cap_idx;

   assign req_ready  = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
   assign accept     = req_valid && req_ready;
   assign enter_resp = ((state_q == S_WAIT) && (cnt_q == 4'd1)) || (accept && (WAIT_CYC == 0));

   // Zero-wait captures use the address on the request bus; otherwise the latched one.
   assign cap_addr = (state_q == S_WAIT) ? addr_q : req_addr;
   assign cap_idx  = cap_addr[DEPTH_LOG2+1:2];
   assign cap_err  = (cap_addr[1:0] != 2'b00) || ((cap_addr >> (DEPTH_LOG2 + 2)) != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= NOP_WORD;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= enter_resp || ((state_q == S_RESP) && !rsp_ready);
         if (enter_resp) begin
            rsp_err_q  <= cap_err;
            rsp_data_q <= cap_err ? NOP_WORD : mem_q[cap_idx];
         end
         if (accept) begin
            addr_q  <= req_addr;
            cnt_q   <= WAIT_INIT;
            state_q <= (WAIT_CYC == 0) ? S_RESP : S_WAIT;
         end else begin
            case (state_q)
               S_WAIT: begin
                  cnt_q <= cnt_q - 4'd1;
                  if (cnt_q == 4'd1) state_q <= S_RESP;
               end
               S_RESP: begin
                  if (rsp_ready) state_q <= S_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   // Load writes land after the same-edge capture read, so collisions return the old word.
   always_ff @(posedge clk) begin
      if (ld_we) mem_q[ld_addr] <= ld_wdata;
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

`ifdef INST_FETCH_RESP_STATS_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (rsp_valid_q && rsp_ready) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
         if (rsp_err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign err_cnt   = err_cnt_q;
`else
   assign fetch_cnt = '0;
   assign err_cnt   = '0;
`endif

endmodule
